// File: rtl/div_pkg.sv
// Shared definitions for the round-robin restoring divider.
package div_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // Widest supported operand. The divide-by-zero quotient is this
    // constant truncated to the instance width.
    localparam int unsigned MaxWidth = 32;
    localparam logic [MaxWidth-1:0] DzQuotient = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    // The incoming remainder is always below the divisor, so its MSB is never set.
    logic           unused_rem_msb;

    assign unused_rem_msb = rem_i[WIDTH];

    // Trial subtract; a set MSB means the subtraction went negative.
    always_comb begin
        shifted = {rem_i[WIDTH-1:0], dividend_bit_i};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[WIDTH]) begin
            rem_o   = shifted;
            q_bit_o = 1'b0;
        end else begin
            rem_o   = trial;
            q_bit_o = 1'b1;
        end
    end

endmodule

// File: rtl/div_sched.sv
// Two-requester round-robin front end around a bit-serial restoring divider.
module div_sched
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_id,
    output logic             rsp_dz
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    // aq_q holds the dividend; quotient bits shift in from the bottom as it empties.
    logic [WIDTH-1:0] aq_q, aq_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             dz_q, dz_d;
    logic             last_q, last_d;

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   step_rem;
    logic             step_q_bit;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i         (rem_q),
        .dividend_bit_i(aq_q[WIDTH-1]),
        .divisor_i     (b_q),
        .rem_o         (step_rem),
        .q_bit_o       (step_q_bit)
    );

    // Round-robin pick: on contention favour the requester not served last.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = req1_valid;
        end
        sel_a  = grant ? req1_a : req0_a;
        sel_b  = grant ? req1_b : req0_b;
        accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (sel_b == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: capture on accept, one quotient bit per CALC cycle.
    always_comb begin
        aq_d   = aq_q;
        b_d    = b_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        id_d   = id_q;
        dz_d   = dz_q;
        last_d = last_q;
        if (state_q == StIdle && accept) begin
            id_d   = grant;
            last_d = grant;
            b_d    = sel_b;
            cnt_d  = '0;
            if (sel_b == '0) begin
                aq_d  = DzQuotient[WIDTH-1:0];
                rem_d = {1'b0, sel_a};
                dz_d  = 1'b1;
            end else begin
                aq_d  = sel_a;
                rem_d = '0;
                dz_d  = 1'b0;
            end
        end else if (state_q == StCalc) begin
            aq_d  = {aq_q[WIDTH-2:0], step_q_bit};
            rem_d = step_rem;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath registers; the grant pointer resets so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aq_q   <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            id_q   <= 1'b0;
            dz_q   <= 1'b0;
            last_q <= 1'b1;
        end else begin
            aq_q   <= aq_d;
            b_q    <= b_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            id_q   <= id_d;
            dz_q   <= dz_d;
            last_q <= last_d;
        end
    end

    // Outputs: ready only in IDLE out of reset; results only visible in DONE.
    always_comb begin
        req0_ready = (state_q == StIdle) && !rst && req0_valid && !grant;
        req1_ready = (state_q == StIdle) && !rst && req1_valid && grant;
        rsp_valid  = (state_q == StDone);
        rsp_q      = rsp_valid ? aq_q : '0;
        rsp_r      = rsp_valid ? rem_q[WIDTH-1:0] : '0;
        rsp_id     = rsp_valid && id_q;
        rsp_dz     = rsp_valid && dz_q;
    end

endmodule
